// File: rtl/seg7_pkg.sv
// Shared constants for the common-anode 7-segment driver and monitor.
// Glyph table is active-low {g,f,e,d,c,b,a}, indexed by hex value.
package seg7_pkg;

    localparam logic [6:0] BLANK_CODE = 7'h7F;

    localparam logic [15:0][6:0] GLYPHS = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam logic [0:0] S_QUAL   = 1'b0;
    localparam logic [0:0] S_COMMIT = 1'b1;

    // One conditioned sample of the display lines; sel_en is 1 = digit enabled.
    typedef struct packed {
        logic       sel_en;
        logic       dp;
        logic [6:0] seg;
    } sample_t;

    localparam sample_t BLANK_SAMPLE = '{sel_en: 1'b0, dp: 1'b1, seg: BLANK_CODE};

endpackage

// File: rtl/seg7_ca_monitor_if.sv
// Raw display lines between a 7-segment driver (master) and a monitor (slave).
interface seg7_ca_monitor_if;
    logic [6:0] seg_in;
    logic       dp_in;
    logic       sel_in;

    modport master (output seg_in, dp_in, sel_in);
    modport slave  (input  seg_in, dp_in, sel_in);
endinterface

// File: rtl/seg7_ca_glyph_decode.sv
// Active-low segment pattern to hex value, with blank and unknown-pattern flags.
module seg7_ca_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] hex,
    output logic       is_blank,
    output logic       is_err
);

    always_comb begin
        hex      = 4'h0;
        is_blank = 1'b0;
        is_err   = 1'b1;
        if (pattern == BLANK_CODE) begin
            is_blank = 1'b1;
            is_err   = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            if (pattern == GLYPHS[i]) begin
                hex    = 4'(i);
                is_err = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_ca_monitor.sv
// Samples a common-anode 7-segment digit, debounces it over several sample
// ticks and reports each newly stable pattern as a decoded hex value.
module seg7_ca_monitor
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_DIV        = 50000,
    parameter int unsigned STABLE_CNT     = 4,
    parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
    input  logic              clk50MHz,
    input  logic              rst,
    seg7_ca_monitor_if.slave  pads,
    output logic [3:0]        hex_out,
    output logic              dp_out,
    output logic              blank,
    output logic              pattern_err,
    output logic              valid,
    output logic [7:0]        change_count
);

    localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned STAB_W = $clog2(STABLE_CNT + 1);
    localparam logic [8:0]  RAW_IDLE = {SEL_ACTIVE_LOW, 1'b1, BLANK_CODE};

    logic [8:0]        sync1, sync2;
    logic              sel_en;
    sample_t           sample_c;
    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic [0:0]        state, state_next;
    sample_t           cand, cand_next, committed;
    logic [STAB_W-1:0] stab_cnt, stab_next;
    logic              commit_go;
    logic [3:0]        dec_hex;
    logic              dec_blank, dec_err;

    // Two-flop synchroniser on all nine raw lines, idling as a deselected digit.
    always_ff @(posedge clk50MHz) begin
        if (rst) begin
            sync1 <= RAW_IDLE;
            sync2 <= RAW_IDLE;
        end else begin
            sync1 <= {pads.sel_in, pads.dp_in, pads.seg_in};
            sync2 <= sync1;
        end
    end

    assign sel_en   = sync2[8] ^ SEL_ACTIVE_LOW;
    assign sample_c = sel_en ? sample_t'({1'b1, sync2[7:0]}) : BLANK_SAMPLE;

    assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk50MHz) begin
        if (rst || tick) div_cnt <= '0;
        else             div_cnt <= div_cnt + DIV_W'(1);
    end

    always_ff @(posedge clk50MHz) begin
        if (rst) state <= S_QUAL;
        else     state <= state_next;
    end

    // Qualification: count identical ticks, commit once a new pattern is stable.
    always_comb begin
        state_next = state;
        cand_next  = cand;
        stab_next  = stab_cnt;
        commit_go  = 1'b0;
        case (state)
            S_QUAL: begin
                if (tick) begin
                    if (sample_c == cand) begin
                        if (stab_cnt != STAB_W'(STABLE_CNT)) stab_next = stab_cnt + STAB_W'(1);
                    end else begin
                        cand_next = sample_c;
                        stab_next = STAB_W'(1);
                    end
                    if ((stab_next == STAB_W'(STABLE_CNT)) && (cand_next != committed)) begin
                        commit_go  = 1'b1;
                        state_next = S_COMMIT;
                    end
                end
            end
            default: state_next = S_QUAL;
        endcase
    end

    seg7_ca_glyph_decode u_decode (
        .pattern  (cand.seg),
        .hex      (dec_hex),
        .is_blank (dec_blank),
        .is_err   (dec_err)
    );

    // Outputs are loaded on the tick edge so they are visible during S_COMMIT.
    always_ff @(posedge clk50MHz) begin
        if (rst) begin
            cand         <= BLANK_SAMPLE;
            committed    <= BLANK_SAMPLE;
            stab_cnt     <= '0;
            hex_out      <= 4'h0;
            dp_out       <= 1'b0;
            blank        <= 1'b1;
            pattern_err  <= 1'b0;
            valid        <= 1'b0;
            change_count <= 8'h00;
        end else begin
            cand     <= cand_next;
            stab_cnt <= stab_next;
            valid    <= commit_go;
            if (commit_go) begin
                committed    <= cand;
                dp_out       <= ~cand.dp;
                change_count <= change_count + 8'd1;
                blank        <= dec_blank;
                pattern_err  <= dec_err;
                if (!dec_blank && !dec_err) hex_out <= dec_hex;
            end
        end
    end

endmodule

// File: tb/tb_seg7_ca_monitor.sv
// Directed bench for seg7_ca_monitor: stimulus pushes expected commits into a
// queue, a concurrent monitor pops and compares on every valid pulse.
module tb_seg7_ca_monitor;

    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned STABLE_CNT = 3;
    localparam int unsigned HOLD       = 24;

    typedef struct packed {
        logic [3:0] hex;
        logic       dp;
        logic       blank;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    logic       clk50MHz = 1'b0;
    logic       rst      = 1'b1;
    logic [3:0] hex_out;
    logic       dp_out, blank, pattern_err, valid;
    logic [7:0] change_count;

    int         errors = 0;
    int         checks = 0;
    exp_t       exp_q[$];
    logic [7:0] exp_cnt = 8'h00;
    logic       done = 1'b0;

    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_ca_monitor_if pads ();

    seg7_ca_monitor #(
        .CLK_DIV        (CLK_DIV),
        .STABLE_CNT     (STABLE_CNT),
        .SEL_ACTIVE_LOW (1'b1)
    ) dut (
        .clk50MHz     (clk50MHz),
        .rst          (rst),
        .pads         (pads),
        .hex_out      (hex_out),
        .dp_out       (dp_out),
        .blank        (blank),
        .pattern_err  (pattern_err),
        .valid        (valid),
        .change_count (change_count)
    );

    always #10 clk50MHz = ~clk50MHz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic drive(input logic sel, input logic dp, input logic [6:0] seg);
        @(posedge clk50MHz);
        #1;
        pads.sel_in = sel;
        pads.dp_in  = dp;
        pads.seg_in = seg;
    endtask

    task automatic expect_commit(input logic [3:0] hex, input logic dp, input logic blk, input logic err);
        exp_t e;
        exp_cnt = exp_cnt + 8'd1;
        e = '{hex: hex, dp: dp, blank: blk, err: err, cnt: exp_cnt};
        exp_q.push_back(e);
    endtask

    task automatic check_outputs(input string name, input logic [3:0] hex, input logic dp,
                                 input logic blk, input logic err, input logic [7:0] cnt);
        check(name, {20'h0, hex_out, dp_out, blank, pattern_err, change_count},
                    {20'h0, hex, dp, blk, err, cnt});
    endtask

    initial begin
        pads.sel_in = 1'b1;
        pads.dp_in  = 1'b1;
        pads.seg_in = 7'h7F;
        fork
            begin : monitor
                while (!done) begin
                    @(negedge clk50MHz);
                    if (valid) begin
                        if (exp_q.size() == 0) begin
                            check("valid_without_expectation", 32'(valid), 32'h0);
                        end else begin
                            exp_t e;
                            e = exp_q.pop_front();
                            check("commit", 32'({hex_out, dp_out, blank, pattern_err, change_count}),
                                            32'(e));
                        end
                    end
                end
            end
            begin : stimulus
                repeat (3) @(posedge clk50MHz);
                #1 rst = 1'b0;
                @(negedge clk50MHz);
                check_outputs("reset_state", 4'h0, 1'b0, 1'b1, 1'b0, 8'h00);
                check("reset_valid", 32'(valid), 32'h0);

                // Deselected digit equals the reset pattern: nothing to report.
                repeat (50) @(posedge clk50MHz);
                #1 check_outputs("deselected_idle", 4'h0, 1'b0, 1'b1, 1'b0, 8'h00);

                drive(1'b0, 1'b1, 7'h24);
                expect_commit(4'h2, 1'b0, 1'b0, 1'b0);
                repeat (HOLD) @(posedge clk50MHz);
                #1 check_outputs("glyph_2", 4'h2, 1'b0, 1'b0, 1'b0, 8'h01);

                // Two ticks of F, then back to 2: never qualifies.
                drive(1'b0, 1'b1, 7'h0E);
                repeat (7) @(posedge clk50MHz);
                drive(1'b0, 1'b1, 7'h24);
                repeat (HOLD) @(posedge clk50MHz);
                #1 check_outputs("short_glitch", 4'h2, 1'b0, 1'b0, 1'b0, 8'h01);

                drive(1'b0, 1'b1, 7'h55);
                expect_commit(4'h2, 1'b0, 1'b0, 1'b1);
                repeat (HOLD) @(posedge clk50MHz);
                drive(1'b0, 1'b1, 7'h00);
                expect_commit(4'h8, 1'b0, 1'b0, 1'b0);
                repeat (HOLD) @(posedge clk50MHz);
                #1 check_outputs("glyph_8", 4'h8, 1'b0, 1'b0, 1'b0, 8'h03);

                // Deselect with dp line low: blank, dp forced dark, hex held.
                drive(1'b1, 1'b0, 7'h40);
                expect_commit(4'h8, 1'b0, 1'b1, 1'b0);
                repeat (HOLD) @(posedge clk50MHz);

                // Driver loopback sweep, enough commits to wrap change_count.
                for (int n = 0; n < 252; n++) begin
                    drive(1'b0, ~n[0], glyph_tab[n % 16]);
                    expect_commit(4'(n % 16), n[0], 1'b0, 1'b0);
                    repeat (HOLD) @(posedge clk50MHz);
                end
                #1 check_outputs("sweep_wrap", 4'hB, 1'b1, 1'b0, 1'b0, 8'h00);

                // Reset midway through qualifying 1; it must re-qualify afterwards.
                drive(1'b0, 1'b1, 7'h79);
                repeat (7) @(posedge clk50MHz);
                #1 rst = 1'b1;
                @(posedge clk50MHz);
                #1 rst = 1'b0;
                check_outputs("mid_qual_reset", 4'h0, 1'b0, 1'b1, 1'b0, 8'h00);
                check("mid_qual_reset_valid", 32'(valid), 32'h0);
                exp_cnt = 8'h00;
                expect_commit(4'h1, 1'b0, 1'b0, 1'b0);
                repeat (HOLD) @(posedge clk50MHz);
                #1 check_outputs("requalify_1", 4'h1, 1'b0, 1'b0, 1'b0, 8'h01);

                done = 1'b1;
            end
        join
        check("pending_expectations", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
